// File: rtl/arbiter_rr_hold_pkg.sv
// rtl/arbiter_rr_hold_pkg.sv - shared state encoding and width helper for the hold arbiter
package arbiter_rr_hold_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } arb_state_e;

   function automatic int clog2(input int value);
      int res;
      int v;
      res = 0;
      v   = value - 1;
      while (v > 0) begin
         res = res + 1;
         v   = v >> 1;
      end
      return res;
   endfunction

endpackage

// File: rtl/arbiter_rr_hold_rr_pick.sv
// rtl/arbiter_rr_hold_rr_pick.sv - combinational round-robin pick, ptr has highest priority
module rr_pick #(
   parameter int N    = 8,
   parameter int ID_W = 3
) (
   input  logic [N-1:0]    req,
   input  logic [ID_W-1:0] ptr,
   output logic [N-1:0]    onehot,
   output logic [ID_W-1:0] id,
   output logic            any
);

   logic [2*N-1:0] dbl;
   logic [N-1:0]   rot;
   int             off;
   int             idx;

   always_comb begin
      dbl = {req, req};
      rot = '0;
      for (int i = 0; i < N; i++) begin
         rot[i] = dbl[i + int'(ptr)];
      end
      any = |rot;
      // Scan downward so the lowest set bit of the rotated vector wins.
      off = 0;
      for (int i = N - 1; i >= 0; i--) begin
         if (rot[i]) off = i;
      end
      idx = off + int'(ptr);
      if (idx >= N) idx = idx - N;
      id     = any ? ID_W'(idx) : '0;
      onehot = '0;
      for (int j = 0; j < N; j++) begin
         onehot[j] = any && (j == idx);
      end
   end

endmodule

// File: rtl/arbiter_rr_hold.sv
// rtl/arbiter_rr_hold.sv - round-robin arbiter holding a multi-beat resource until last/drop/watchdog
module arbiter_rr_hold
   import arbiter_rr_hold_pkg::*;
#(
   parameter int N        = 8,
   parameter int MAX_HOLD = 16,
   parameter int ID_W     = clog2(N),
   parameter int HOLD_W   = clog2(MAX_HOLD)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N-1:0]    req,
   input  logic            last,
   output logic [N-1:0]    gnt,
   output logic            gnt_valid,
   output logic [ID_W-1:0] gnt_id,
   output logic            timeout
);

   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
   localparam logic [ID_W-1:0]   ID_LAST   = ID_W'(N - 1);

   arb_state_e        state_q, state_d;
   logic [ID_W-1:0]   ptr_q, ptr_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [N-1:0]      gnt_q, gnt_d;
   logic              gnt_valid_q, gnt_valid_d;
   logic [ID_W-1:0]   gnt_id_q, gnt_id_d;
   logic              timeout_q, timeout_d;

   logic              busy, rel_last, rel_drop, rel_to, rel_any;
   logic [ID_W-1:0]   ptr_next;
   logic [N-1:0]      req_next;
   logic [N-1:0]      pick_req;
   logic [ID_W-1:0]   pick_ptr;
   logic [N-1:0]      pick_onehot;
   logic [ID_W-1:0]   pick_id;
   logic              pick_any;

   always_comb begin
      busy     = (state_q == ST_BUSY);
      // A dropped request wins over a coincident last so the owner is removed from the handover pick.
      rel_drop = busy && !req[gnt_id_q];
      rel_last = busy && last && !rel_drop;
      rel_to   = busy && !last && !rel_drop && (hold_q == HOLD_LAST);
      rel_any  = rel_last || rel_drop || rel_to;
      ptr_next = (gnt_id_q == ID_LAST) ? '0 : gnt_id_q + ID_W'(1);
      req_next = req;
      if (rel_drop) req_next[gnt_id_q] = 1'b0;
      pick_req = busy ? req_next : req;
      pick_ptr = busy ? ptr_next : ptr_q;
   end

   rr_pick #(
      .N    (N),
      .ID_W (ID_W)
   ) u_pick (
      .req    (pick_req),
      .ptr    (pick_ptr),
      .onehot (pick_onehot),
      .id     (pick_id),
      .any    (pick_any)
   );

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      hold_d      = hold_q;
      gnt_d       = gnt_q;
      gnt_valid_d = gnt_valid_q;
      gnt_id_d    = gnt_id_q;
      timeout_d   = 1'b0;
      if (!busy) begin
         if (pick_any) begin
            state_d     = ST_BUSY;
            gnt_d       = pick_onehot;
            gnt_valid_d = 1'b1;
            gnt_id_d    = pick_id;
            hold_d      = '0;
         end
      end else if (rel_any) begin
         ptr_d     = ptr_next;
         timeout_d = rel_to;
         hold_d    = '0;
         if (pick_any) begin
            gnt_d       = pick_onehot;
            gnt_valid_d = 1'b1;
            gnt_id_d    = pick_id;
         end else begin
            state_d     = ST_IDLE;
            gnt_d       = '0;
            gnt_valid_d = 1'b0;
            gnt_id_d    = '0;
         end
      end else begin
         hold_d = hold_q + HOLD_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         ptr_q       <= '0;
         hold_q      <= '0;
         gnt_q       <= '0;
         gnt_valid_q <= 1'b0;
         gnt_id_q    <= '0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         hold_q      <= hold_d;
         gnt_q       <= gnt_d;
         gnt_valid_q <= gnt_valid_d;
         gnt_id_q    <= gnt_id_d;
         timeout_q   <= timeout_d;
      end
   end

   assign gnt       = gnt_q;
   assign gnt_valid = gnt_valid_q;
   assign gnt_id    = gnt_id_q;
   assign timeout   = timeout_q;

endmodule

// File: tb/tb_arbiter_rr_hold.sv
// tb/tb_arbiter_rr_hold.sv - self-checking bench with a queue-free reference model of the hold arbiter
module tb_arbiter_rr_hold;

   localparam int N        = 8;
   localparam int MAX_HOLD = 16;

   logic         clk;
   logic         rst_n;
   logic [N-1:0] req;
   logic         last;
   logic [N-1:0] gnt;
   logic         gnt_valid;
   logic [2:0]   gnt_id;
   logic         timeout;

   int n_checks;
   int n_pass;

   // Reference model: owner index (-1 when idle), priority pointer, cycles held, timeout pulse.
   int m_owner;
   int m_ptr;
   int m_hold;
   bit m_to;

   arbiter_rr_hold #(
      .N        (N),
      .MAX_HOLD (MAX_HOLD)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .last      (last),
      .gnt       (gnt),
      .gnt_valid (gnt_valid),
      .gnt_id    (gnt_id),
      .timeout   (timeout)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic int pick(input logic [N-1:0] r, input int p);
      for (int k = 0; k < N; k++) begin
         if (r[(p + k) % N]) return (p + k) % N;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_owner = -1;
      m_ptr   = 0;
      m_hold  = 0;
      m_to    = 1'b0;
   endtask

   task automatic model_step();
      logic [N-1:0] r2;
      bit           dropped, ended, expired;
      m_to = 1'b0;
      if (m_owner < 0) begin
         m_owner = pick(req, m_ptr);
         m_hold  = 0;
      end else begin
         dropped = !req[m_owner];
         ended   = last;
         expired = !dropped && !ended && (m_hold == MAX_HOLD - 1);
         if (dropped || ended || expired) begin
            r2 = req;
            if (dropped) r2[m_owner] = 1'b0;
            m_ptr   = (m_owner + 1) % N;
            m_to    = expired;
            m_owner = pick(r2, m_ptr);
            m_hold  = 0;
         end else begin
            m_hold = m_hold + 1;
         end
      end
   endtask

   task automatic cycle(input logic [N-1:0] r, input logic l);
      req  = r;
      last = l;
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic apply_reset(input logic [N-1:0] r);
      rst_n = 1'b0;
      req   = r;
      last  = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   always @(negedge clk) begin
      logic [N-1:0] exp_gnt;
      if (rst_n) begin
         exp_gnt = '0;
         if (m_owner >= 0) exp_gnt[m_owner] = 1'b1;
         n_checks++;
         if (gnt !== exp_gnt || gnt_valid !== (m_owner >= 0) || timeout !== m_to ||
             int'(gnt_id) !== ((m_owner < 0) ? 0 : m_owner)) begin
            $display("FAIL model_cmp t=%0t gnt=%h exp=%h id=%0d exp=%0d vld=%b to=%b exp=%b",
                     $time, gnt, exp_gnt, gnt_id, m_owner, gnt_valid, timeout, m_to);
         end else n_pass++;
         n_checks++;
         if (!$onehot0(gnt) || gnt_valid !== (|gnt)) begin
            $display("FAIL invariant t=%0t gnt=%h gnt_valid=%b", $time, gnt, gnt_valid);
         end else n_pass++;
      end
   end

   task automatic test_reset();
      apply_reset(8'hFF);
      n_checks++;
      if (gnt !== 8'h00 || gnt_valid !== 1'b0 || gnt_id !== 3'd0 || timeout !== 1'b0) begin
         $display("FAIL reset_outputs gnt=%h vld=%b id=%0d to=%b required all zero",
                  gnt, gnt_valid, gnt_id, timeout);
      end else n_pass++;
      cycle(8'hFF, 1'b0);
      n_checks++;
      if (gnt !== 8'h01 || gnt_id !== 3'd0) begin
         $display("FAIL first_grant gnt=%h id=%0d required 01/0", gnt, gnt_id);
      end else n_pass++;
      cycle(8'hFF, 1'b1);
      n_checks++;
      if (gnt !== 8'h02) begin
         $display("FAIL handover_no_bubble gnt=%h required 02", gnt);
      end else n_pass++;
   endtask

   task automatic test_single_regrant();
      apply_reset(8'h00);
      cycle(8'h20, 1'b0);
      for (int k = 0; k < 4; k++) begin
         cycle(8'h20, 1'b0);
         cycle(8'h20, 1'b0);
         cycle(8'h20, 1'b1);
         n_checks++;
         if (gnt !== 8'h20 || dut.ptr_q !== 3'd6 || timeout !== 1'b0) begin
            $display("FAIL single_regrant k=%0d gnt=%h ptr=%0d to=%b required 20/6/0",
                     k, gnt, dut.ptr_q, timeout);
         end else n_pass++;
      end
   endtask

   task automatic test_timeout();
      int held;
      apply_reset(8'h00);
      cycle(8'h80, 1'b0);
      held = (gnt === 8'h80) ? 1 : 0;
      while (gnt === 8'h80 && held < 40) begin
         cycle(8'h81, 1'b0);
         if (gnt === 8'h80) held++;
      end
      n_checks++;
      if (held !== MAX_HOLD) begin
         $display("FAIL timeout_hold_len held=%0d required %0d", held, MAX_HOLD);
      end else n_pass++;
      n_checks++;
      if (timeout !== 1'b1 || gnt !== 8'h01) begin
         $display("FAIL timeout_pulse to=%b gnt=%h required 1/01", timeout, gnt);
      end else n_pass++;
      cycle(8'h81, 1'b0);
      n_checks++;
      if (timeout !== 1'b0) begin
         $display("FAIL timeout_one_cycle to=%b required 0", timeout);
      end else n_pass++;
   endtask

   task automatic test_drop_with_last();
      apply_reset(8'h00);
      cycle(8'h08, 1'b0);
      cycle(8'h08, 1'b0);
      cycle(8'h00, 1'b1);
      n_checks++;
      if (gnt !== 8'h00 || gnt_valid !== 1'b0 || dut.ptr_q !== 3'd4 || timeout !== 1'b0) begin
         $display("FAIL drop_with_last gnt=%h vld=%b ptr=%0d to=%b required 00/0/4/0",
                  gnt, gnt_valid, dut.ptr_q, timeout);
      end else n_pass++;
   endtask

   task automatic test_fairness();
      int cnt [N];
      int expect_id;
      int order_err;
      for (int i = 0; i < N; i++) cnt[i] = 0;
      expect_id = 0;
      order_err = 0;
      apply_reset(8'h00);
      for (int c = 0; c < 1000; c++) begin
         cycle(8'hFF, 1'b1);
         if (gnt_valid === 1'b1) cnt[gnt_id]++;
         if (int'(gnt_id) !== expect_id) order_err++;
         expect_id = (expect_id + 1) % N;
      end
      for (int i = 0; i < N; i++) begin
         n_checks++;
         if (cnt[i] !== 125) begin
            $display("FAIL fairness_count id=%0d got=%0d required 125", i, cnt[i]);
         end else n_pass++;
      end
      n_checks++;
      if (order_err !== 0) begin
         $display("FAIL fairness_order out_of_order=%0d required 0", order_err);
      end else n_pass++;
   endtask

   task automatic test_random();
      logic [N-1:0] r;
      int           dut_to, mdl_to;
      dut_to = 0;
      mdl_to = 0;
      r = '0;
      apply_reset(8'h00);
      for (int c = 0; c < 2400; c++) begin
         if ($urandom_range(0, 3) == 0) r = N'($urandom);
         if (c < 1200) cycle(r, $urandom_range(0, 3) == 0);
         else          cycle(r, $urandom_range(0, 31) == 0);
         if (timeout === 1'b1) dut_to++;
         if (m_to) mdl_to++;
      end
      n_checks++;
      if (dut_to !== mdl_to) begin
         $display("FAIL random_timeouts got=%0d required %0d", dut_to, mdl_to);
      end else n_pass++;
   endtask

   task automatic test_reset_mid_busy();
      apply_reset(8'h00);
      cycle(8'h10, 1'b0);
      cycle(8'h30, 1'b0);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      n_checks++;
      if (gnt !== 8'h00 || gnt_valid !== 1'b0 || gnt_id !== 3'd0) begin
         $display("FAIL async_reset gnt=%h vld=%b id=%0d required 00/0/0", gnt, gnt_valid, gnt_id);
      end else n_pass++;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      cycle(8'h30, 1'b0);
      n_checks++;
      if (gnt !== 8'h10 || gnt_id !== 3'd4) begin
         $display("FAIL restart_ptr0 gnt=%h id=%0d required 10/4", gnt, gnt_id);
      end else n_pass++;
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      rst_n    = 1'b0;
      req      = '0;
      last     = 1'b0;
      model_reset();
      test_reset();
      test_single_regrant();
      test_timeout();
      test_drop_with_last();
      test_fairness();
      test_random();
      test_reset_mid_busy();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
